// File: rtl/ldpc_byte_sink.sv
// ldpc_byte_sink: packs the LDPC decoder's serial hard-decision stream into
// MSB-first bytes, tags the first/last byte of each frame, and buffers the
// bytes in a small FIFO presented on a valid/ready interface.
module ldpc_byte_sink #(
    parameter int FIFO_DEP = 4,
    parameter int LEN_R12  = 4608,
    parameter int LEN_R34  = 6912,
    parameter int CNT_WID  = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_in,
    input  logic        sync_in,
    input  logic        rate,
    input  logic [4:0]  num_iter,
    output logic [7:0]  byte_out,
    output logic        byte_sof,
    output logic        byte_eof,
    output logic        byte_vld,
    input  logic        byte_rdy,
    output logic [4:0]  frame_iter,
    output logic [15:0] frame_cnt,
    output logic        frame_err,
    output logic        ovf
);

    localparam int AW = $clog2(FIFO_DEP);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    localparam logic [CNT_WID-1:0] LEN12 = CNT_WID'(LEN_R12);
    localparam logic [CNT_WID-1:0] LEN34 = CNT_WID'(LEN_R34);

    // Receive side
    logic [0:0]         state;
    logic [CNT_WID-1:0] len;
    logic [CNT_WID-1:0] bitcnt;
    logic [7:0]         shreg;
    logic               sof_pend;
    logic               wr_req;
    logic [9:0]         wr_ent;   // {sof, eof, byte}

    logic [CNT_WID-1:0] bitcnt_nxt;
    logic [7:0]         shreg_nxt;
    logic               byte_done;
    logic               is_last;

    // FIFO
    logic [9:0]         mem [FIFO_DEP];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               fifo_full;
    logic               fifo_empty;
    logic               rd_en;
    logic               wr_en;
    logic               wr_drop;
    logic [9:0]         head;

    assign bitcnt_nxt = bitcnt + 1'b1;
    assign shreg_nxt  = {shreg[6:0], data_in};
    assign byte_done  = (state == RECV) && sync_in && (bitcnt_nxt[2:0] == 3'd0);
    assign is_last    = (bitcnt_nxt == len);

    // Frame FSM: bit counting, byte packing, and the registered FIFO write request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len        <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            sof_pend   <= 1'b0;
            frame_iter <= '0;
            frame_err  <= 1'b0;
            wr_req     <= 1'b0;
            wr_ent     <= '0;
        end else begin
            frame_err <= 1'b0;
            wr_req    <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_in) begin
                        len        <= rate ? LEN34 : LEN12;
                        frame_iter <= num_iter;
                        shreg      <= {7'd0, data_in};
                        bitcnt     <= {{(CNT_WID-1){1'b0}}, 1'b1};
                        sof_pend   <= 1'b1;
                        state      <= RECV;
                    end
                end
                RECV: begin
                    if (sync_in) begin
                        shreg  <= shreg_nxt;
                        bitcnt <= bitcnt_nxt;
                        if (byte_done) begin
                            // The byte is queued one cycle later; a reset in
                            // between discards it along with the frame.
                            wr_req   <= 1'b1;
                            wr_ent   <= {sof_pend, is_last, shreg_nxt};
                            sof_pend <= 1'b0;
                            // Leaving now lets IDLE take the very next bit.
                            if (is_last) state <= IDLE;
                        end
                    end else begin
                        // Stream stopped early: partial byte is dropped.
                        if (bitcnt < len) frame_err <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en      = !fifo_empty && byte_rdy;
    assign wr_en      = wr_req && (!fifo_full || rd_en);
    assign wr_drop    = wr_req && fifo_full && !rd_en;

    // FIFO pointers: a write into a full FIFO is allowed when the head leaves this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage.
    // NOTE: storage is deliberately not reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_ent;
    end

    // Frame counter and sticky overflow; an eof counts whether stored or dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            ovf       <= 1'b0;
        end else begin
            if (wr_req && wr_ent[8]) frame_cnt <= frame_cnt + 1'b1;
            if (wr_drop)             ovf       <= 1'b1;
        end
    end

    // Head entry is masked while empty so stale storage never shows on the outputs.
    assign head     = mem[rd_ptr[AW-1:0]];
    assign byte_vld = !fifo_empty;
    assign byte_out = byte_vld ? head[7:0] : 8'd0;
    assign byte_eof = byte_vld & head[8];
    assign byte_sof = byte_vld & head[9];

endmodule

// File: tb/tb_ldpc_byte_sink.sv
// Bench for ldpc_byte_sink: table of whole-frame scenarios plus hand-written
// corner sequences; expected bytes are queued as bits are driven and compared
// on every downstream transfer.
module tb_ldpc_byte_sink;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_in = 1'b0;
    logic        sync_in = 1'b0;
    logic        rate = 1'b0;
    logic [4:0]  num_iter = '0;
    logic        byte_rdy = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_sof;
    logic        byte_eof;
    logic        byte_vld;
    logic [4:0]  frame_iter;
    logic [15:0] frame_cnt;
    logic        frame_err;
    logic        ovf;

    ldpc_byte_sink dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .sync_in    (sync_in),
        .rate       (rate),
        .num_iter   (num_iter),
        .byte_out   (byte_out),
        .byte_sof   (byte_sof),
        .byte_eof   (byte_eof),
        .byte_vld   (byte_vld),
        .byte_rdy   (byte_rdy),
        .frame_iter (frame_iter),
        .frame_cnt  (frame_cnt),
        .frame_err  (frame_err),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [9:0] exp_q[$];
    int         err_cnt  = 0;
    int         sof_seen = 0;
    int         eof_seen = 0;
    int         exp_fcnt = 0;

    typedef struct {
        logic       rate;
        logic [4:0] iter;
        int         nbits;
        int         pat;      // 0: 0xA5 repeat, 1: incrementing bytes, 2: random
        int         err;      // expected frame_err pulses
        int         eof;      // expected eof markers
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted byte is compared against the queue head.
    always @(negedge clk) begin
        logic [9:0] e;
        if (!reset && frame_err) err_cnt++;
        if (!reset && byte_vld && byte_rdy) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_byte: got 0x%0h with no byte expected",
                         {byte_sof, byte_eof, byte_out});
            end else begin
                e = exp_q.pop_front();
                check("byte", {22'd0, byte_sof, byte_eof, byte_out}, {22'd0, e});
                sof_seen += int'(byte_sof);
                eof_seen += int'(byte_eof);
            end
        end
    end

    function automatic logic pat_bit(input int pat, input int idx);
        logic [7:0] b;
        case (pat)
            0:       b = 8'hA5;
            1:       b = 8'(idx / 8);
            default: b = 8'($urandom_range(0, 255));
        endcase
        return b[7 - (idx % 8)];
    endfunction

    // Drives nbits of one frame, queuing the first `keep` complete bytes.
    task automatic drive_frame(input logic r, input logic [4:0] it, input int nbits,
                               input int pat, input int keep);
        int         len;
        logic [7:0] acc;
        logic       b;
        len = r ? 6912 : 4608;
        acc = '0;
        for (int i = 0; i < nbits; i++) begin
            b = pat_bit(pat, i);
            @(posedge clk);
            #1;
            sync_in = 1'b1;
            data_in = b;
            if (i == 0) begin
                rate     = r;
                num_iter = it;
            end else begin
                rate     = 1'($urandom_range(0, 1));
                num_iter = 5'($urandom_range(0, 31));
            end
            acc = {acc[6:0], b};
            if ((i % 8) == 7 && (i / 8) < keep)
                exp_q.push_back({(i / 8) == 0, (i + 1) == len, acc});
        end
    endtask

    task automatic end_frame();
        @(posedge clk);
        #1;
        sync_in = 1'b0;
        data_in = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_vld_idle"}, {31'd0, byte_vld}, 0);
    endtask

    initial begin
        int e0, s0, f0;

        vecs[0] = '{rate: 1'b0, iter: 5'd3,  nbits: 4608, pat: 0, err: 0, eof: 1};
        vecs[1] = '{rate: 1'b1, iter: 5'd7,  nbits: 6912, pat: 1, err: 0, eof: 1};
        vecs[2] = '{rate: 1'b0, iter: 5'd12, nbits: 1003, pat: 2, err: 1, eof: 0};
        vecs[3] = '{rate: 1'b0, iter: 5'd1,  nbits: 4608, pat: 2, err: 0, eof: 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld",   {31'd0, byte_vld}, 0);
        check("rst_out",   {24'd0, byte_out}, 0);
        check("rst_sof",   {31'd0, byte_sof}, 0);
        check("rst_eof",   {31'd0, byte_eof}, 0);
        check("rst_cnt",   {16'd0, frame_cnt}, 0);
        check("rst_iter",  {27'd0, frame_iter}, 0);
        check("rst_err",   {31'd0, frame_err}, 0);
        check("rst_ovf",   {31'd0, ovf}, 0);
        reset    = 1'b0;
        byte_rdy = 1'b1;

        // Table-driven single frames
        for (int v = 0; v < 4; v++) begin
            e0 = err_cnt; s0 = sof_seen; f0 = eof_seen;
            drive_frame(vecs[v].rate, vecs[v].iter, vecs[v].nbits, vecs[v].pat, 1 << 20);
            end_frame();
            if (vecs[v].eof != 0) exp_fcnt++;
            wait_drain($sformatf("vec%0d", v));
            check($sformatf("vec%0d_err",  v), err_cnt - e0, vecs[v].err);
            check($sformatf("vec%0d_sof",  v), sof_seen - s0, 1);
            check($sformatf("vec%0d_eof",  v), eof_seen - f0, vecs[v].eof);
            check($sformatf("vec%0d_cnt",  v), {16'd0, frame_cnt}, exp_fcnt);
            check($sformatf("vec%0d_iter", v), {27'd0, frame_iter}, {27'd0, vecs[v].iter});
            check($sformatf("vec%0d_ovf",  v), {31'd0, ovf}, 0);
        end

        // Back-to-back frames with continuous sync_in
        e0 = err_cnt; s0 = sof_seen; f0 = eof_seen;
        drive_frame(1'b0, 5'd4, 4608, 2, 1 << 20);
        drive_frame(1'b1, 5'd9, 6912, 1, 1 << 20);
        end_frame();
        exp_fcnt += 2;
        wait_drain("b2b");
        check("b2b_sof",  sof_seen - s0, 2);
        check("b2b_eof",  eof_seen - f0, 2);
        check("b2b_err",  err_cnt - e0, 0);
        check("b2b_cnt",  {16'd0, frame_cnt}, exp_fcnt);
        check("b2b_iter", {27'd0, frame_iter}, 9);

        // Stalled downstream for a whole frame: only the first 4 bytes survive
        byte_rdy = 1'b0;
        drive_frame(1'b0, 5'd2, 4608, 1, 4);
        end_frame();
        exp_fcnt++;
        repeat (5) @(posedge clk);
        #1;
        check("ovf_flag",  {31'd0, ovf}, 1);
        check("ovf_cnt",   {16'd0, frame_cnt}, exp_fcnt);
        check("ovf_vld",   {31'd0, byte_vld}, 1);
        check("ovf_head",  {22'd0, byte_sof, byte_eof, byte_out}, 32'h200);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_hold",  {22'd0, byte_sof, byte_eof, byte_out}, 32'h200);
        byte_rdy = 1'b1;
        wait_drain("ovf");
        check("ovf_sticky", {31'd0, ovf}, 1);

        // Reset in the middle of a frame
        e0 = err_cnt;
        drive_frame(1'b0, 5'd11, 1999, 2, 1 << 20);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        sync_in = 1'b0;
        check("mid_q_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
        check("mid_vld",  {31'd0, byte_vld}, 0);
        check("mid_out",  {24'd0, byte_out}, 0);
        check("mid_cnt",  {16'd0, frame_cnt}, 0);
        check("mid_iter", {27'd0, frame_iter}, 0);
        check("mid_ovf",  {31'd0, ovf}, 0);
        check("mid_err",  {31'd0, frame_err}, 0);
        reset    = 1'b0;
        exp_fcnt = 0;
        repeat (3) @(posedge clk);
        check("mid_no_err", err_cnt - e0, 0);
        drive_frame(1'b1, 5'd6, 6912, 2, 1 << 20);
        end_frame();
        exp_fcnt++;
        wait_drain("post_rst");
        check("post_rst_cnt",  {16'd0, frame_cnt}, exp_fcnt);
        check("post_rst_iter", {27'd0, frame_iter}, 6);

        // Latency: vld rises two edges after the 8th bit is driven
        e0 = err_cnt;
        drive_frame(1'b0, 5'd5, 8, 1, 1 << 20);
        end_frame();
        @(negedge clk);
        check("lat_vld_early", {31'd0, byte_vld}, 0);
        @(negedge clk);
        check("lat_vld_rise",  {31'd0, byte_vld}, 1);
        wait_drain("lat");
        check("lat_err", err_cnt - e0, 1);
        check("lat_cnt", {16'd0, frame_cnt}, exp_fcnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
